br_redirect_ctrl: RTL and testbench

Sequencing controller for the dual-issue branch unit. It takes the per-slot branch resolution results (mispredict flags and corrected targets) in the EX stage and picks the single redirect the frontend must take, giving priority to the older A slot. It issues the registered redirect/flush pulse, masks wrong-path resolutions in the shadow cycle, queues branch-outcome records for predictor training through a valid/ready FIFO, and maintains performance counters. It sits between the EX-stage branch function unit and the fetch/predictor logic.

---
 rtl/br_redirect_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_br_redirect_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/br_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// br_redirect_ctrl : dual-slot branch redirect select, predictor-update FIFO,
//                    and branch performance counters.
// Rev 1.0
// ============================================================================
module br_redirect_ctrl #(
    parameter int UPD_DEPTH = 4,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             stall,

    input  logic             EX_valid_a,
    input  logic             EX_is_br_a,
    input  logic             EX_br_pd_a,
    input  logic             EX_br_a,
    input  logic [31:0]      EX_pc_a,
    input  logic [31:0]      EX_pc_br_a,

    input  logic             EX_valid_b,
    input  logic             EX_is_br_b,
    input  logic             EX_br_pd_b,
    input  logic             EX_br_b,
    input  logic [31:0]      EX_pc_b,
    input  logic [31:0]      EX_pc_br_b,

    output logic             kill_b,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,

    output logic             upd_valid,
    input  logic             upd_ready,
    output logic [31:0]      upd_pc,
    output logic             upd_taken,
    output logic             upd_mispred,
    output logic             upd_afull,
    output logic             upd_ovf,

    output logic [CNT_W-1:0] cnt_br,
    output logic [CNT_W-1:0] cnt_mis
);

    localparam int AW = $clog2(UPD_DEPTH);
    localparam int PW = AW + 1;

    localparam logic [0:0]  S_IDLE  = 1'b0;
    localparam logic [0:0]  S_REDIR = 1'b1;

    localparam logic [PW:0] DEPTH_C = (PW+1)'(UPD_DEPTH);
    localparam logic [PW:0] ONE_C   = (PW+1)'(1);
    localparam logic [PW:0] TWO_C   = (PW+1)'(2);

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic        mis;
    } upd_rec_t;

    // ------------------------------------------------------------------
    // Event qualification and redirect selection
    // ------------------------------------------------------------------
    logic [0:0] state;
    logic       idle;
    logic       ev_a;
    logic       ev_b;
    logic       mis_a;
    logic       mis_b;
    logic       redir_go;

    assign idle     = (state == S_IDLE);
    assign ev_a     = EX_valid_a & EX_is_br_a & ~stall & idle;
    assign mis_a    = ev_a & EX_br_a;
    // An A mispredict makes B wrong-path, so B is never resolved alongside it.
    assign ev_b     = EX_valid_b & EX_is_br_b & ~stall & idle & ~mis_a;
    assign mis_b    = ev_b & EX_br_b;
    assign redir_go = mis_a | mis_b;
    assign kill_b   = mis_a & EX_valid_b;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= S_IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            state          <= redir_go ? S_REDIR : S_IDLE;
            redirect_valid <= redir_go;
            if (redir_go) begin
                redirect_pc <= mis_a ? EX_pc_br_a : EX_pc_br_b;
            end
        end
    end

    // ------------------------------------------------------------------
    // Predictor-update FIFO
    // ------------------------------------------------------------------
    upd_rec_t        mem [UPD_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_idx_a;
    logic [AW-1:0]   wr_idx_b;
    logic [PW:0]     used;
    logic [PW:0]     free_eff;
    logic [PW:0]     need_b;
    logic [PW:0]     used_next;
    logic            pop;
    logic            push_a;
    logic            push_b;
    logic            drop;
    upd_rec_t        rec_a;
    upd_rec_t        rec_b;
    upd_rec_t        head;

    assign upd_valid = (wr_ptr != rd_ptr);
    assign pop       = upd_valid & upd_ready;

    // Pointer difference modulo 2*DEPTH is the occupancy 0..DEPTH.
    assign used      = {1'b0, wr_ptr - rd_ptr};
    assign free_eff  = DEPTH_C - used + (PW+1)'(pop);

    // Space is granted in age order: A first, so B is the one dropped.
    assign push_a    = ev_a & (free_eff != '0);
    assign need_b    = (PW+1)'(push_a) + ONE_C;
    assign push_b    = ev_b & (free_eff >= need_b);
    assign drop      = (ev_a & ~push_a) | (ev_b & ~push_b);

    assign used_next = used + (PW+1)'(push_a) + (PW+1)'(push_b) - (PW+1)'(pop);

    assign wr_idx_a  = wr_ptr[AW-1:0];
    assign wr_idx_b  = wr_ptr[AW-1:0] + AW'(push_a);

    assign rec_a     = '{pc: EX_pc_a, taken: EX_br_pd_a ^ EX_br_a, mis: EX_br_a};
    assign rec_b     = '{pc: EX_pc_b, taken: EX_br_pd_b ^ EX_br_b, mis: EX_br_b};

    always_ff @(posedge clk) begin
        if (push_a) begin
            mem[wr_idx_a] <= rec_a;
        end
        if (push_b) begin
            mem[wr_idx_b] <= rec_b;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            upd_afull <= 1'b0;
            upd_ovf   <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr + PW'(push_a) + PW'(push_b);
            rd_ptr    <= rd_ptr + PW'(pop);
            upd_afull <= (DEPTH_C - used_next) < TWO_C;
            if (drop) begin
                upd_ovf <= 1'b1;
            end
        end
    end

    assign head        = mem[rd_ptr[AW-1:0]];
    assign upd_pc      = head.pc;
    assign upd_taken   = head.taken;
    assign upd_mispred = head.mis;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_br  <= '0;
            cnt_mis <= '0;
        end else begin
            cnt_br  <= cnt_br + CNT_W'(ev_a) + CNT_W'(ev_b);
            cnt_mis <= cnt_mis + CNT_W'(redir_go);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_br_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// tb_br_redirect_ctrl : directed vector table plus multi-cycle sequences.
// Rev 1.0
// ============================================================================
module tb_br_redirect_ctrl;

    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic        clk = 1'b0;
    logic        rstn;
    logic        stall;
    logic        EX_valid_a, EX_is_br_a, EX_br_pd_a, EX_br_a;
    logic [31:0] EX_pc_a, EX_pc_br_a;
    logic        EX_valid_b, EX_is_br_b, EX_br_pd_b, EX_br_b;
    logic [31:0] EX_pc_b, EX_pc_br_b;
    logic        kill_b, redirect_valid;
    logic [31:0] redirect_pc;
    logic        upd_valid, upd_ready, upd_taken, upd_mispred, upd_afull, upd_ovf;
    logic [31:0] upd_pc;
    logic [31:0] cnt_br, cnt_mis;

    br_redirect_ctrl #(.UPD_DEPTH(4), .CNT_W(32)) dut (
        .clk(clk), .rstn(rstn), .stall(stall),
        .EX_valid_a(EX_valid_a), .EX_is_br_a(EX_is_br_a), .EX_br_pd_a(EX_br_pd_a),
        .EX_br_a(EX_br_a), .EX_pc_a(EX_pc_a), .EX_pc_br_a(EX_pc_br_a),
        .EX_valid_b(EX_valid_b), .EX_is_br_b(EX_is_br_b), .EX_br_pd_b(EX_br_pd_b),
        .EX_br_b(EX_br_b), .EX_pc_b(EX_pc_b), .EX_pc_br_b(EX_pc_br_b),
        .kill_b(kill_b), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_mispred(upd_mispred),
        .upd_afull(upd_afull), .upd_ovf(upd_ovf),
        .cnt_br(cnt_br), .cnt_mis(cnt_mis)
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nfail   = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        stall = 1'b0;
        EX_valid_a = 1'b0; EX_is_br_a = 1'b0; EX_br_pd_a = 1'b0; EX_br_a = 1'b0;
        EX_pc_a = '0; EX_pc_br_a = '0;
        EX_valid_b = 1'b0; EX_is_br_b = 1'b0; EX_br_pd_b = 1'b0; EX_br_b = 1'b0;
        EX_pc_b = '0; EX_pc_br_b = '0;
    endtask

    task automatic set_a(input logic v, input logic isb, input logic pd, input logic br,
                         input logic [31:0] pc, input logic [31:0] pcbr);
        EX_valid_a = v; EX_is_br_a = isb; EX_br_pd_a = pd; EX_br_a = br;
        EX_pc_a = pc; EX_pc_br_a = pcbr;
    endtask

    task automatic set_b(input logic v, input logic isb, input logic pd, input logic br,
                         input logic [31:0] pc, input logic [31:0] pcbr);
        EX_valid_b = v; EX_is_br_b = isb; EX_br_pd_b = pd; EX_br_b = br;
        EX_pc_b = pc; EX_pc_br_b = pcbr;
    endtask

    typedef struct {
        logic        stall;
        logic        va, isa, pda, bra;
        logic [31:0] pca, pcbra;
        logic        vb, isb, pdb, brb;
        logic [31:0] pcb, pcbrb;
        logic        kill, rv;
        logic [31:0] rpc;
        int          nrec;
        logic [31:0] r0pc;
        logic        r0t, r0m;
        logic [31:0] r1pc;
        logic        r1t, r1m;
        int          dbr, dmis;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] br0, mis0;
    logic [31:0] exp_pc [4];
    logic        exp_tk [4];

    initial begin
        // A mispredicts, B also mispredicts but is killed
        vecs[0] = '{F, T,T,F,T, 32'h1C000000, 32'h1C000040, T,T,T,T, 32'h1C000004, 32'h1C000100,
                    T, T, 32'h1C000040, 1, 32'h1C000000, T, T, 32'h0, F, F, 1, 1};
        // A correct not-taken, B mispredicts taken->not-taken
        vecs[1] = '{F, T,T,F,F, 32'h1C000100, 32'h1C000180, T,T,T,T, 32'h1C000104, 32'h1C000108,
                    F, T, 32'h1C000108, 2, 32'h1C000100, F, F, 32'h1C000104, F, T, 2, 1};
        // A correct taken, B valid non-branch
        vecs[2] = '{F, T,T,T,F, 32'h1C000400, 32'h1C000500, T,F,F,T, 32'h1C000404, 32'hDEAD0000,
                    F, F, 32'h0, 1, 32'h1C000400, T, F, 32'h0, F, F, 1, 0};
        // A invalid (flags ignored), B mispredicts not-taken->taken
        vecs[3] = '{F, F,T,F,T, 32'h1C000200, 32'hBAD00000, T,T,F,T, 32'h1C000204, 32'h1C000300,
                    F, T, 32'h1C000300, 1, 32'h1C000204, T, T, 32'h0, F, F, 1, 1};
        // stalled A mispredict: nothing consumed
        vecs[4] = '{T, T,T,F,T, 32'h1C000500, 32'h1C000600, F,F,F,F, 32'h0, 32'h0,
                    F, F, 32'h0, 0, 32'h0, F, F, 32'h0, F, F, 0, 0};
        // A non-branch with stray br flag, B correct not-taken
        vecs[5] = '{F, T,F,F,T, 32'h1C000600, 32'hDEAD0000, T,T,F,F, 32'h1C000604, 32'h1C000700,
                    F, F, 32'h0, 1, 32'h1C000604, F, F, 32'h0, F, F, 1, 0};
        // A mispredict taken->not-taken, B invalid: no kill
        vecs[6] = '{F, T,T,T,T, 32'h1C000700, 32'h1C000704, F,T,F,T, 32'h1C000708, 32'hBAD00000,
                    F, T, 32'h1C000704, 1, 32'h1C000700, F, T, 32'h0, F, F, 1, 1};
        // nothing valid
        vecs[7] = '{F, F,F,F,F, 32'h0, 32'h0, F,F,F,F, 32'h0, 32'h0,
                    F, F, 32'h0, 0, 32'h0, F, F, 32'h0, F, F, 0, 0};

        clr();
        upd_ready = 1'b1;
        rstn = 1'b0;
        tick();
        tick();
        chk1 ("rst redirect_valid", redirect_valid, 1'b0);
        chk32("rst redirect_pc",    redirect_pc,    32'h0);
        chk1 ("rst upd_valid",      upd_valid,      1'b0);
        chk1 ("rst upd_afull",      upd_afull,      1'b0);
        chk1 ("rst upd_ovf",        upd_ovf,        1'b0);
        chk32("rst cnt_br",         cnt_br,         32'h0);
        chk32("rst cnt_mis",        cnt_mis,        32'h0);
        rstn = 1'b1;
        tick();

        // ---------------- table-driven single-event vectors ----------------
        for (int i = 0; i < 8; i++) begin
            br0  = cnt_br;
            mis0 = cnt_mis;
            stall = vecs[i].stall;
            set_a(vecs[i].va, vecs[i].isa, vecs[i].pda, vecs[i].bra, vecs[i].pca, vecs[i].pcbra);
            set_b(vecs[i].vb, vecs[i].isb, vecs[i].pdb, vecs[i].brb, vecs[i].pcb, vecs[i].pcbrb);
            #1;
            chk1($sformatf("v%0d kill_b", i), kill_b, vecs[i].kill);
            tick();
            clr();
            chk1($sformatf("v%0d redirect_valid", i), redirect_valid, vecs[i].rv);
            if (vecs[i].rv)
                chk32($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].rpc);
            chk1($sformatf("v%0d upd_valid", i), upd_valid, vecs[i].nrec != 0);
            if (vecs[i].nrec != 0) begin
                chk32($sformatf("v%0d rec0 pc", i), upd_pc, vecs[i].r0pc);
                chk1 ($sformatf("v%0d rec0 taken", i), upd_taken, vecs[i].r0t);
                chk1 ($sformatf("v%0d rec0 mis", i), upd_mispred, vecs[i].r0m);
            end
            chk32($sformatf("v%0d cnt_br", i),  cnt_br,  br0 + 32'(vecs[i].dbr));
            chk32($sformatf("v%0d cnt_mis", i), cnt_mis, mis0 + 32'(vecs[i].dmis));
            tick();
            chk1($sformatf("v%0d pulse ends", i), redirect_valid, 1'b0);
            if (vecs[i].nrec == 2) begin
                chk1 ($sformatf("v%0d rec1 valid", i), upd_valid, 1'b1);
                chk32($sformatf("v%0d rec1 pc", i), upd_pc, vecs[i].r1pc);
                chk1 ($sformatf("v%0d rec1 taken", i), upd_taken, vecs[i].r1t);
                chk1 ($sformatf("v%0d rec1 mis", i), upd_mispred, vecs[i].r1m);
            end
            tick();
            chk1($sformatf("v%0d fifo drained", i), upd_valid, 1'b0);
        end

        // ---------------- mispredict held under stall ----------------
        br0  = cnt_br;
        mis0 = cnt_mis;
        stall = 1'b1;
        set_a(T, T, T, T, 32'h30000000, 32'h30000100);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk1 ($sformatf("stall%0d redirect_valid", k), redirect_valid, 1'b0);
            chk1 ($sformatf("stall%0d upd_valid", k), upd_valid, 1'b0);
            chk32($sformatf("stall%0d cnt_br", k), cnt_br, br0);
        end
        stall = 1'b0;
        tick();
        chk1 ("unstall redirect_valid", redirect_valid, 1'b1);
        chk32("unstall redirect_pc", redirect_pc, 32'h30000100);
        chk1 ("unstall upd_valid", upd_valid, 1'b1);
        chk32("unstall upd_pc", upd_pc, 32'h30000000);
        chk32("unstall cnt_br", cnt_br, br0 + 32'd1);
        chk32("unstall cnt_mis", cnt_mis, mis0 + 32'd1);
        tick();
        chk1 ("shadow redirect_valid", redirect_valid, 1'b0);
        chk1 ("shadow no push", upd_valid, 1'b0);
        chk32("shadow cnt_br", cnt_br, br0 + 32'd1);
        clr();
        tick();

        // ---------------- second mispredict in the shadow cycle ----------------
        br0  = cnt_br;
        mis0 = cnt_mis;
        set_a(T, T, F, T, 32'h40000000, 32'h40000100);
        tick();
        chk1 ("shd redirect_valid", redirect_valid, 1'b1);
        chk32("shd redirect_pc", redirect_pc, 32'h40000100);
        clr();
        set_b(T, T, F, T, 32'h50000004, 32'h50000000);
        tick();
        chk1 ("shd second pulse", redirect_valid, 1'b0);
        chk32("shd redirect_pc hold", redirect_pc, 32'h40000100);
        chk1 ("shd no record", upd_valid, 1'b0);
        chk32("shd cnt_br", cnt_br, br0 + 32'd1);
        chk32("shd cnt_mis", cnt_mis, mis0 + 32'd1);
        clr();
        tick();
        chk1("shd quiet", redirect_valid, 1'b0);

        // ---------------- FIFO fill, overflow and drain ----------------
        br0 = cnt_br;
        upd_ready = 1'b0;
        chk1("fifo ovf clear", upd_ovf, 1'b0);
        exp_pc[0] = 32'h20000000; exp_tk[0] = 1'b0;
        exp_pc[1] = 32'h20000010; exp_tk[1] = 1'b0;
        exp_pc[2] = 32'h20000020; exp_tk[2] = 1'b1;
        exp_pc[3] = 32'h20000030; exp_tk[3] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_a(T, T, exp_tk[k], F, exp_pc[k], 32'h0);
            tick();
            chk1($sformatf("fill%0d afull", k), upd_afull, k == 2);
        end
        set_a(T, T, F, F, 32'h20000030, 32'h0);
        set_b(T, T, F, F, 32'h20000034, 32'h0);
        tick();
        clr();
        chk1 ("ovf set", upd_ovf, 1'b1);
        chk1 ("ovf afull", upd_afull, 1'b1);
        chk32("ovf cnt_br", cnt_br, br0 + 32'd5);
        chk32("ovf head intact", upd_pc, 32'h20000000);
        tick();
        upd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk1 ($sformatf("drain%0d valid", k), upd_valid, 1'b1);
            chk32($sformatf("drain%0d pc", k), upd_pc, exp_pc[k]);
            chk1 ($sformatf("drain%0d taken", k), upd_taken, exp_tk[k]);
            tick();
        end
        chk1("drain empty", upd_valid, 1'b0);
        chk1("drain afull", upd_afull, 1'b0);
        chk1("drain ovf sticky", upd_ovf, 1'b1);

        // ---------------- asynchronous reset during REDIR ----------------
        set_a(T, T, F, T, 32'h60000000, 32'h60000100);
        tick();
        clr();
        chk1("pre-rst redirect_valid", redirect_valid, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        chk1 ("arst redirect_valid", redirect_valid, 1'b0);
        chk32("arst redirect_pc", redirect_pc, 32'h0);
        chk1 ("arst upd_valid", upd_valid, 1'b0);
        chk1 ("arst upd_ovf", upd_ovf, 1'b0);
        chk32("arst cnt_br", cnt_br, 32'h0);
        chk32("arst cnt_mis", cnt_mis, 32'h0);
        tick();
        rstn = 1'b1;
        tick();
        chk1("post-rst no pulse", redirect_valid, 1'b0);
        tick();
        chk1("post-rst still quiet", redirect_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
`default_nettype wire
